tone_gen: RTL and testbench

//  Square-wave note player for the music game's speaker output. Sits directly

---
 rtl/tone_gen.sv | 154 +++++++++++++++
 tb/tb_tone_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_gen.sv
// Square-wave note player timed by rising edges of the sampled /2 divider output.
// Define TONE_GAP_EN to insert GAP_TICKS silent ticks after every note.
`timescale 1ns/1ps
module tone_gen #(
  parameter int unsigned HALF_W    = 16,
  parameter int unsigned DUR_W     = 16,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              div_clk,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [HALF_W-1:0] note_period,
  input  logic [DUR_W-1:0]  note_dur,
  output logic              audio_out,
  output logic              busy,
  output logic              note_done
);

`ifdef TONE_GAP_EN
  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;
  localparam int unsigned GapW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
`else
  typedef enum logic [1:0] {StIdle, StPlay} state_e;
`endif

  state_e state_q, state_d;
  logic              div_q;
  logic              tick;
  logic              accept;
  logic [HALF_W-1:0] period_q, period_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic              audio_q, audio_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  assign tick   = div_clk & ~div_q;
  assign accept = note_valid & ready_q;

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    dur_d      = dur_q;
    dur_cnt_d  = dur_cnt_q;
    half_cnt_d = half_cnt_q;
    audio_d    = audio_q;
    done_d     = 1'b0;
`ifdef TONE_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          period_d   = note_period;
          dur_d      = note_dur;
          dur_cnt_d  = '0;
          half_cnt_d = '0;
          audio_d    = 1'b0;
          // An empty note completes immediately without leaving idle.
          if (note_dur == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StPlay;
          end
        end
      end
      StPlay: begin
        if (tick) begin
          if (dur_cnt_q == dur_q - DUR_W'(1)) begin
            // End of note overrides any toggle due on the same tick.
            audio_d    = 1'b0;
            done_d     = 1'b1;
            dur_cnt_d  = '0;
            half_cnt_d = '0;
`ifdef TONE_GAP_EN
            gap_cnt_d  = '0;
            state_d    = StGap;
`else
            state_d    = StIdle;
`endif
          end else begin
            dur_cnt_d = dur_cnt_q + DUR_W'(1);
            if (period_q == '0) begin
              half_cnt_d = '0;
            end else if (half_cnt_q == period_q - HALF_W'(1)) begin
              half_cnt_d = '0;
              audio_d    = ~audio_q;
            end else begin
              half_cnt_d = half_cnt_q + HALF_W'(1);
            end
          end
        end
      end
`ifdef TONE_GAP_EN
      StGap: begin
        if (tick) begin
          if (gap_cnt_q == GapW'(GAP_TICKS - 1)) begin
            gap_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            gap_cnt_d = gap_cnt_q + GapW'(1);
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle) & ~accept;
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= 1'b0;
      period_q   <= '0;
      dur_q      <= '0;
      dur_cnt_q  <= '0;
      half_cnt_q <= '0;
      audio_q    <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TONE_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_clk;
      period_q   <= period_d;
      dur_q      <= dur_d;
      dur_cnt_q  <= dur_cnt_d;
      half_cnt_q <= half_cnt_d;
      audio_q    <= audio_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef TONE_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign note_ready = ready_q;
  assign audio_out  = audio_q;
  assign busy       = busy_q;
  assign note_done  = done_q;

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: vector table of notes with hand-derived per-tick audio patterns,
// checked through a scoreboard queue, plus reset, stall and gap sequences.
`timescale 1ns/1ps
module tb_tone_gen;
  localparam int unsigned HALF_W    = 16;
  localparam int unsigned DUR_W     = 16;
  localparam int unsigned GAP_TICKS = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              div_clk = 1'b0;
  logic              note_valid = 1'b0;
  logic [HALF_W-1:0] note_period = '0;
  logic [DUR_W-1:0]  note_dur = '0;
  logic              note_ready, audio_out, busy, note_done;

  logic tb_tick = 1'b0;  // DUT tick at the next posedge
  logic stall   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  bit   sb[$];

  typedef struct {
    int unsigned period;
    int unsigned dur;
    logic [15:0] exp_audio;  // bit i = audio_out during tick i
  } vec_t;

  vec_t vecs[8];

  tone_gen #(
    .HALF_W   (HALF_W),
    .DUR_W    (DUR_W),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_clk    (div_clk),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_period(note_period),
    .note_dur   (note_dur),
    .audio_out  (audio_out),
    .busy       (busy),
    .note_done  (note_done)
  );

  always #5 clk = ~clk;

  initial begin
    logic old;
    forever begin
      @(posedge clk);
      #1;
      old = div_clk;
      if (!stall) div_clk = ~div_clk;
      tb_tick = div_clk & ~old;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Scoreboard consumer: one expected audio value per tick while a note is in progress.
  always @(negedge clk) begin
    if (rst_n && busy) begin
      check("ready_while_busy", note_ready, 0);
      if (tb_tick) begin
        if (sb.size() == 0) fail("sb_underflow");
        else check("audio_tick", audio_out, sb.pop_front());
      end
    end
  end

  task automatic send_note(input int unsigned p, input int unsigned d, input logic [15:0] exp);
    int n = 0;
    @(negedge clk);
    while (!note_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!note_ready) fail("ready_timeout");
    note_valid  = 1'b1;
    note_period = HALF_W'(p);
    note_dur    = DUR_W'(d);
    @(posedge clk);
    #1 note_valid = 1'b0;
    for (int i = 0; i < int'(d); i++) sb.push_back(exp[i]);
`ifdef TONE_GAP_EN
    if (d != 0) for (int i = 0; i < int'(GAP_TICKS); i++) sb.push_back(1'b0);
`endif
  endtask

  task automatic wait_done(input int unsigned d, input bit chk_busy);
    int  busy_cnt = 0;
    int  k = 0;
    bit  first_tick;
    if (d == 0) begin
      @(negedge clk);
      check("empty_done", note_done, 1);
      check("empty_busy", busy, 0);
      check("empty_ready_low", note_ready, 0);
      check("empty_audio", audio_out, 0);
      @(negedge clk);
      check("empty_done_pulse", note_done, 0);
      check("empty_ready_back", note_ready, 1);
      return;
    end
    @(negedge clk);
    first_tick = tb_tick;
    while (!note_done && k < int'(8 * d + 100)) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    if (!note_done) begin
      fail("done_timeout");
      return;
    end
    check("done_audio", audio_out, 0);
`ifdef TONE_GAP_EN
    check("done_busy_gap", busy, 1);
`else
    check("done_busy", busy, 0);
    check("done_sb_empty", sb.size(), 0);
    if (chk_busy) check("busy_cycles", busy_cnt, first_tick ? 2 * d - 1 : 2 * d);
`endif
    @(negedge clk);
    check("done_pulse", note_done, 0);
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_busy", busy, 0);
    check("idle_sb_empty", sb.size(), 0);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs = '{
      '{2,     8, 16'h00CC},
      '{0,     5, 16'h0000},
      '{1,     4, 16'h000A},
      '{3,     7, 16'h0038},
      '{0,     0, 16'h0000},
      '{5,     0, 16'h0000},
      '{65535, 3, 16'h0000},
      '{4,     9, 16'h00F0}
    };

    // Reset values and ready timing after release.
    #12;
    check("rst_audio", audio_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", note_ready, 0);
    check("rst_done", note_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", note_ready, 0);
    @(negedge clk);
    check("ready_after_release", note_ready, 1);
    check("idle_audio", audio_out, 0);
    check("idle_busy0", busy, 0);

    foreach (vecs[i]) begin
      send_note(vecs[i].period, vecs[i].dur, vecs[i].exp_audio);
      wait_done(vecs[i].dur, 1'b1);
    end

    // Stalled divider mid-note: everything holds, pattern resumes on later ticks.
    send_note(2, 6, 16'h000C);
    repeat (5) @(negedge clk);
    stall = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("stall_busy", busy, 1);
    end
    stall = 1'b0;
    wait_done(6, 1'b0);

    // Asynchronous reset mid-note, then a fresh note plays from scratch.
    send_note(1, 10, 16'h02AA);
    n = 0;
    while (n < 3) begin
      @(negedge clk);
      if (tb_tick && busy) n++;
    end
    @(posedge clk);
    #2 check("pre_reset_audio", audio_out, 1);
    rst_n = 1'b0;
    #1;
    check("abort_audio", audio_out, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", note_ready, 0);
    check("abort_done", note_done, 0);
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", note_done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_back", note_ready, 1);
    check("abort_no_done2", note_done, 0);
    send_note(1, 4, 16'h000A);
    wait_done(4, 1'b1);

`ifdef TONE_GAP_EN
    // Back-to-back notes: gap ticks are silent and hold off the second accept.
    send_note(1, 2, 16'h0002);
    wait_done(2, 1'b0);
    send_note(2, 4, 16'h000C);
    wait_done(4, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
